audio_sample_feeder: RTL and testbench
======================================

// Module: audio_sample_feeder
// PURPOSE
//  Sits between the synth ALUcontroller wave output and Audio_Controller.
//  Samples the free-running unsigned wave at the codec rate and converts it to signed, left-justified 32-bit.
//  Buffers the samples in a small FIFO and writes them to the controller with a paced handshake.
//  Replaces the tie-off of write_audio_out to 1, which writes on every clock.
// PARAMETERS
//  IN_W        7     width of unsigned offset-binary wave_in
//  OUT_W       32    audio sample width expected by Audio_Controller
//  DEPTH       8     FIFO entries, power of 2, >=2
//  SAMPLE_DIV  1042  CLOCK_50 cycles per captured sample (~48 kHz)
// PORTS
//  CLOCK_50                 in   1            system clock, 50 MHz
//  reset                    in   1            synchronous, active-high
//  enable                   in   1            1 = capture samples
//  mute                     in   1            1 = push zero samples instead of wave_in
//  wave_in                  in   IN_W         unsigned wave; 2^(IN_W-1) = silence
//  audio_out_allowed        in   1            from Audio_Controller; 1 = may write
//  left_channel_audio_out   out  OUT_W        sample to controller
//  right_channel_audio_out  out  OUT_W        identical to left
//  write_audio_out          out  1            one-cycle write strobe
//  fifo_level               out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
//  overrun                  out  1            sticky; set when a sample is dropped
//  dropped_count            out  8            saturating count of dropped samples (stops at 255)
// BEHAVIOUR
//  Reset:
//   - All outputs, FIFO pointers, divider and FSM go to zero / IDLE on the same edge.
//   - Applies mid-operation: FIFO contents are discarded; no write strobe is issued in the cycle after reset.
//  Divider:
//   - div counts 0..SAMPLE_DIV-1 while enable=1, then wraps to 0.
//   - div is held at 0 while enable=0.
//   - The cycle with div==SAMPLE_DIV-1 is the capture strobe.
//  Conversion (combinational on capture):
//   - s = {~wave_in[IN_W-1], wave_in[IN_W-2:0], (OUT_W-IN_W)'b0}.
//   - If mute=1, s = 0.
//  Push:
//   - On the capture strobe, s is written at the FIFO tail at the end of that cycle.
//   - If the FIFO is full and no pop occurs in that cycle, the sample is dropped:
//     - overrun is set (cleared only by reset).
//     - dropped_count increments, saturating at 255.
//   - Full with a pop in the same cycle: push is accepted; fifo_level is unchanged.
//  Drain FSM, states IDLE and WRITE:
//   - IDLE -> WRITE when audio_out_allowed=1 && fifo_level!=0. On this edge:
//     - the head is popped;
//     - left/right are loaded with the head value.
//   - WRITE: write_audio_out=1 for exactly this cycle, then unconditionally -> IDLE.
//   - Maximum rate is one write per 2 cycles.
//   - left/right hold their last value between writes.
//   - audio_out_allowed is sampled only in IDLE. If it drops while in WRITE, that write still issues.
//   - Samples drain in FIFO order, with no loss or duplication.
//  Latency:
//   - Strobe in cycle t with an empty FIFO and allowed=1 gives write_audio_out=1 in cycle t+2.
//   - Data is presented in the same cycle as the strobe.
//  enable=0 stops capture only; draining continues until the FIFO is empty.
//  Pointers wrap modulo DEPTH. Simultaneous push and pop leaves fifo_level unchanged.
// TESTING
//  1 Reset: run traffic, then hold reset 2 cycles ->
//     - all outputs 0, fifo_level 0, FSM IDLE;
//     - first write only after a new capture.
//  2 SAMPLE_DIV=4, allowed=1, wave_in=7'h7F ->
//     - a write every 4 cycles, data 32'h7E000000;
//     - wave_in=7'h00 -> 32'h80000000;
//     - wave_in=7'h40 -> 32'h00000000.
//  3 SAMPLE_DIV=4, allowed=0, 10 strobes with wave_in 1..10 ->
//     - fifo_level=8, overrun=1, dropped_count=2;
//     - then allowed=1 -> 8 writes in order 1..8, 2 cycles apart.
//  4 mute=1 with wave_in=7'h7F -> every write carries 32'h0; left==right always.
//  5 allowed toggled 0/1 every 3 cycles during a drain of 8 ->
//     - no write begins while allowed=0;
//     - all 8 samples arrive exactly once, in order.
//  6 Reset asserted in the WRITE cycle with 5 samples queued ->
//     - next cycle: write_audio_out=0, fifo_level=0, overrun=0, left/right=0.

Source files
------------

// File: rtl/audio_sample_feeder_if.sv
// ---------------------------------------------------------------------------
// audio_sample_feeder_if
//   Write-side handshake between the sample feeder and Audio_Controller.
//   The feeder presents one sample on both channels together with a
//   single-cycle write strobe; the controller tells the feeder when it can
//   accept a write.
//
//   Signals
//     audio_out_allowed        controller -> feeder   1 = a write may be issued
//     left_channel_audio_out   feeder -> controller   signed left-justified sample
//     right_channel_audio_out  feeder -> controller   same value as left
//     write_audio_out          feeder -> controller   one-cycle write strobe
//
//   Modports
//     master  the feeder (drives samples and strobe)
//     slave   the audio controller (drives audio_out_allowed)
// ---------------------------------------------------------------------------
interface audio_sample_feeder_if #(
   parameter int OUT_W = 32
);

   logic             audio_out_allowed;
   logic [OUT_W-1:0] left_channel_audio_out;
   logic [OUT_W-1:0] right_channel_audio_out;
   logic             write_audio_out;

   modport master (
      input  audio_out_allowed,
      output left_channel_audio_out,
      output right_channel_audio_out,
      output write_audio_out
   );

   modport slave (
      output audio_out_allowed,
      input  left_channel_audio_out,
      input  right_channel_audio_out,
      input  write_audio_out
   );

endinterface

// File: rtl/audio_sample_feeder.sv
// ---------------------------------------------------------------------------
// audio_sample_feeder
//   Bridges the free-running synth wave output to Audio_Controller.
//   A divider produces one capture strobe every SAMPLE_DIV clocks; on that
//   strobe the unsigned offset-binary wave is converted to a signed,
//   left-justified OUT_W-bit sample (or zero when muted) and pushed into a
//   small FIFO. A two-state drain FSM pops the FIFO whenever the controller
//   allows it and issues a one-cycle write strobe, so writes are paced at
//   most one every two clocks instead of one every clock.
//
//   Ports
//     CLOCK_50       in   system clock
//     reset          in   synchronous, active-high
//     enable         in   1 = capture samples (draining continues regardless)
//     mute           in   1 = capture zero samples instead of wave_in
//     wave_in        in   unsigned wave, 2^(IN_W-1) is silence
//     aud            if   write handshake to Audio_Controller (master side)
//     fifo_level     out  current FIFO occupancy, 0..DEPTH
//     overrun        out  sticky flag, set when a captured sample is dropped
//     dropped_count  out  saturating count of dropped samples
// ---------------------------------------------------------------------------
module audio_sample_feeder #(
   parameter int IN_W       = 7,
   parameter int OUT_W      = 32,
   parameter int DEPTH      = 8,
   parameter int SAMPLE_DIV = 1042
) (
   input  logic                       CLOCK_50,
   input  logic                       reset,
   input  logic                       enable,
   input  logic                       mute,
   input  logic [IN_W-1:0]            wave_in,
   audio_sample_feeder_if.master      aud,
   output logic [$clog2(DEPTH):0]     fifo_level,
   output logic                       overrun,
   output logic [7:0]                 dropped_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } drain_state_t;

   drain_state_t     state_q;
   drain_state_t     state_d;

   logic [DIV_W-1:0] div_q;
   logic             capture;

   logic [OUT_W-1:0] sample_s;

   logic [OUT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [LVL_W-1:0] level_q;
   logic             fifo_full;
   logic             fifo_empty;

   logic             pop;
   logic             push;
   logic             drop;

   logic [OUT_W-1:0] out_q;
   logic             overrun_q;
   logic [7:0]       dropped_q;

   // Sample-rate divider. It only runs while capture is enabled and sits at
   // zero otherwise, so re-enabling always gives a full SAMPLE_DIV period
   // before the first capture.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         div_q <= '0;
      end else if (!enable) begin
         div_q <= '0;
      end else if (div_q == DIV_LAST) begin
         div_q <= '0;
      end else begin
         div_q <= div_q + DIV_W'(1);
      end
   end

   assign capture = enable && (div_q == DIV_LAST);

   // Offset-binary to two's complement is just an MSB flip; the IN_W bits
   // are then placed at the top of the output word so full-scale input maps
   // to near full-scale output.
   always_comb begin
      sample_s = {~wave_in[IN_W-1], wave_in[IN_W-2:0], {(OUT_W-IN_W){1'b0}}};
      if (mute) begin
         sample_s = '0;
      end
   end

   assign fifo_full  = (level_q == LVL_FULL);
   assign fifo_empty = (level_q == '0);

   // A pop in the same cycle frees the slot, so a capture into a full FIFO
   // is only lost when nothing is leaving. When full, tail and head point at
   // the same entry; the pop reads the old value before the push overwrites it.
   assign push = capture && (!fifo_full || pop);
   assign drop = capture && fifo_full && !pop;

   // Storage array carries no reset: the pointers and level define what is
   // valid, so stale contents after reset are never read.
   always_ff @(posedge CLOCK_50) begin
      if (!reset && push) begin
         mem[wr_ptr_q] <= sample_s;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two. The level
   // counter is kept separately so full and empty are unambiguous.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   level_q <= level_q + LVL_W'(1);
            2'b01:   level_q <= level_q - LVL_W'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // Drop bookkeeping: overrun stays set until reset, the counter stops at
   // its maximum rather than wrapping so a large count is never misread as
   // a small one.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         overrun_q <= 1'b0;
         dropped_q <= '0;
      end else if (drop) begin
         overrun_q <= 1'b1;
         if (dropped_q != 8'hFF) begin
            dropped_q <= dropped_q + 8'd1;
         end
      end
   end

   // Drain FSM state register.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Drain FSM next state. The controller's permission is only looked at in
   // IDLE; once a sample has been popped the write is committed, and the
   // mandatory return to IDLE limits the rate to one write per two clocks.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (aud.audio_out_allowed && !fifo_empty) begin
               pop     = 1'b1;
               state_d = WRITE;
            end
         end
         WRITE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output sample register, loaded on the pop edge so the data is already
   // stable during the WRITE cycle and held between writes.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         out_q <= '0;
      end else if (pop) begin
         out_q <= mem[rd_ptr_q];
      end
   end

   assign aud.left_channel_audio_out  = out_q;
   assign aud.right_channel_audio_out = out_q;
   assign aud.write_audio_out         = (state_q == WRITE);

   assign fifo_level    = level_q;
   assign overrun       = overrun_q;
   assign dropped_count = dropped_q;

endmodule

// File: tb/tb_audio_sample_feeder.sv
// ---------------------------------------------------------------------------
// tb_audio_sample_feeder
//   Directed bench for audio_sample_feeder with a short divider (4 clocks per
//   capture) so every scenario fits in a few dozen cycles. Each scenario is
//   its own task; expected data comes from hand-computed tables.
// ---------------------------------------------------------------------------
module tb_audio_sample_feeder;

   localparam int IN_W  = 7;
   localparam int OUT_W = 32;
   localparam int DEPTH = 8;
   localparam int SDIV  = 4;

   logic              CLOCK_50;
   logic              reset;
   logic              enable;
   logic              mute;
   logic [IN_W-1:0]   wave_in;
   logic [3:0]        fifo_level;
   logic              overrun;
   logic [7:0]        dropped_count;

   int vectors;
   int miscompares;

   // Converted values of wave_in = 1..10 (offset-binary MSB flipped, left-justified).
   logic [31:0] samp_tbl [10];

   audio_sample_feeder_if #(.OUT_W(OUT_W)) aud ();

   audio_sample_feeder #(
      .IN_W       (IN_W),
      .OUT_W      (OUT_W),
      .DEPTH      (DEPTH),
      .SAMPLE_DIV (SDIV)
   ) dut (
      .CLOCK_50      (CLOCK_50),
      .reset         (reset),
      .enable        (enable),
      .mute          (mute),
      .wave_in       (wave_in),
      .aud           (aud.master),
      .fifo_level    (fifo_level),
      .overrun       (overrun),
      .dropped_count (dropped_count)
   );

   // 50 MHz clock
   initial CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;

   // Advance one clock and settle just after the rising edge.
   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   // Two reset cycles; on return the divider is at zero and reset is low.
   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      int writes;
      enable = 1'b1; mute = 1'b0; wave_in = 7'h7F; aud.audio_out_allowed = 1'b0;
      do_reset();
      repeat (44) tick();
      aud.audio_out_allowed = 1'b1;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      tick();
      vectors++;
      if (aud.write_audio_out !== 1'b0) begin
         miscompares++; $display("[TB] FAIL reset_write: got %b expected 0", aud.write_audio_out);
      end
      vectors++;
      if (aud.left_channel_audio_out !== 32'h0 || aud.right_channel_audio_out !== 32'h0) begin
         miscompares++;
         $display("[TB] FAIL reset_data: got %h/%h expected 0/0", aud.left_channel_audio_out, aud.right_channel_audio_out);
      end
      vectors++;
      if (fifo_level !== 4'd0) begin
         miscompares++; $display("[TB] FAIL reset_level: got %0d expected 0", fifo_level);
      end
      vectors++;
      if (overrun !== 1'b0 || dropped_count !== 8'd0) begin
         miscompares++; $display("[TB] FAIL reset_overrun: got %b/%0d expected 0/0", overrun, dropped_count);
      end
      reset = 1'b0;
      writes = 0;
      for (int n = 1; n <= 5; n++) begin
         tick();
         vectors++;
         if (aud.write_audio_out !== (n == 5)) begin
            miscompares++;
            $display("[TB] FAIL reset_first_write: cycle %0d got %b expected %b", n, aud.write_audio_out, (n == 5));
         end
         if (aud.write_audio_out === 1'b1) writes++;
      end
      vectors++;
      if (aud.left_channel_audio_out !== 32'h7E000000) begin
         miscompares++; $display("[TB] FAIL reset_first_data: got %h expected 7e000000", aud.left_channel_audio_out);
      end
   endtask

   task automatic test_conversion();
      logic [6:0]  waves [4];
      logic [31:0] expd  [4];
      logic        exp_wr;
      waves[0] = 7'h7F; waves[1] = 7'h00; waves[2] = 7'h40; waves[3] = 7'h40;
      expd[0]  = 32'h7E000000; expd[1] = 32'h80000000; expd[2] = 32'h00000000; expd[3] = 32'h0;
      enable = 1'b1; mute = 1'b0; aud.audio_out_allowed = 1'b1; wave_in = waves[0];
      do_reset();
      for (int n = 1; n <= 16; n++) begin
         wave_in = waves[(n-1)/4];
         tick();
         exp_wr = (n >= 5) && (((n - 5) % 4) == 0);
         vectors++;
         if (aud.write_audio_out !== exp_wr) begin
            miscompares++;
            $display("[TB] FAIL conv_strobe: cycle %0d got %b expected %b", n, aud.write_audio_out, exp_wr);
         end
         if (exp_wr) begin
            vectors++;
            if (aud.left_channel_audio_out !== expd[(n-5)/4] || aud.right_channel_audio_out !== expd[(n-5)/4]) begin
               miscompares++;
               $display("[TB] FAIL conv_data: cycle %0d got %h/%h expected %h", n,
                        aud.left_channel_audio_out, aud.right_channel_audio_out, expd[(n-5)/4]);
            end
         end
      end
   endtask

   task automatic test_overrun();
      logic exp_wr;
      int   writes;
      enable = 1'b1; mute = 1'b0; aud.audio_out_allowed = 1'b0; wave_in = 7'd1;
      do_reset();
      for (int n = 1; n <= 40; n++) begin
         wave_in = 7'(((n - 1) / 4) + 1);
         tick();
      end
      vectors++;
      if (fifo_level !== 4'd8 || overrun !== 1'b1 || dropped_count !== 8'd2) begin
         miscompares++;
         $display("[TB] FAIL overrun_state: got level %0d ovr %b drop %0d expected 8 1 2",
                  fifo_level, overrun, dropped_count);
      end
      enable = 1'b0;
      aud.audio_out_allowed = 1'b1;
      writes = 0;
      for (int n = 41; n <= 56; n++) begin
         tick();
         exp_wr = (n % 2) == 1;
         vectors++;
         if (aud.write_audio_out !== exp_wr) begin
            miscompares++;
            $display("[TB] FAIL overrun_drain_strobe: cycle %0d got %b expected %b", n, aud.write_audio_out, exp_wr);
         end
         if (exp_wr) begin
            vectors++;
            if (aud.left_channel_audio_out !== samp_tbl[(n-41)/2]) begin
               miscompares++;
               $display("[TB] FAIL overrun_drain_data: cycle %0d got %h expected %h", n,
                        aud.left_channel_audio_out, samp_tbl[(n-41)/2]);
            end
         end
      end
      vectors++;
      if (fifo_level !== 4'd0 || overrun !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL overrun_after_drain: got level %0d ovr %b expected 0 1", fifo_level, overrun);
      end
   endtask

   task automatic test_full_pop();
      logic exp_wr;
      enable = 1'b1; mute = 1'b0; aud.audio_out_allowed = 1'b0; wave_in = 7'd1;
      do_reset();
      for (int n = 1; n <= 36; n++) begin
         wave_in = 7'(((n - 1) / 4) + 1);
         aud.audio_out_allowed = (n == 36);
         tick();
      end
      vectors++;
      if (fifo_level !== 4'd8 || overrun !== 1'b0 || dropped_count !== 8'd0) begin
         miscompares++;
         $display("[TB] FAIL full_pop_state: got level %0d ovr %b drop %0d expected 8 0 0",
                  fifo_level, overrun, dropped_count);
      end
      vectors++;
      if (aud.write_audio_out !== 1'b1 || aud.left_channel_audio_out !== samp_tbl[0]) begin
         miscompares++;
         $display("[TB] FAIL full_pop_first: got %b %h expected 1 %h",
                  aud.write_audio_out, aud.left_channel_audio_out, samp_tbl[0]);
      end
      enable = 1'b0;
      for (int n = 37; n <= 54; n++) begin
         tick();
         exp_wr = (n % 2 == 0) && (n <= 52);
         vectors++;
         if (aud.write_audio_out !== exp_wr) begin
            miscompares++;
            $display("[TB] FAIL full_pop_strobe: cycle %0d got %b expected %b", n, aud.write_audio_out, exp_wr);
         end
         if (exp_wr) begin
            vectors++;
            if (aud.left_channel_audio_out !== samp_tbl[(n-36)/2]) begin
               miscompares++;
               $display("[TB] FAIL full_pop_data: cycle %0d got %h expected %h", n,
                        aud.left_channel_audio_out, samp_tbl[(n-36)/2]);
            end
         end
      end
   endtask

   task automatic test_saturation();
      enable = 1'b1; mute = 1'b0; aud.audio_out_allowed = 1'b0; wave_in = 7'h11;
      do_reset();
      repeat (268 * SDIV) tick();
      vectors++;
      if (dropped_count !== 8'd255 || overrun !== 1'b1 || fifo_level !== 4'd8) begin
         miscompares++;
         $display("[TB] FAIL saturation: got drop %0d ovr %b level %0d expected 255 1 8",
                  dropped_count, overrun, fifo_level);
      end
   endtask

   task automatic test_mute();
      int writes;
      enable = 1'b1; mute = 1'b1; aud.audio_out_allowed = 1'b1; wave_in = 7'h7F;
      do_reset();
      writes = 0;
      for (int n = 1; n <= 16; n++) begin
         tick();
         vectors++;
         if (aud.left_channel_audio_out !== aud.right_channel_audio_out) begin
            miscompares++;
            $display("[TB] FAIL mute_lr: cycle %0d got %h/%h expected equal", n,
                     aud.left_channel_audio_out, aud.right_channel_audio_out);
         end
         if (aud.write_audio_out === 1'b1) begin
            writes++;
            vectors++;
            if (aud.left_channel_audio_out !== 32'h0) begin
               miscompares++;
               $display("[TB] FAIL mute_data: cycle %0d got %h expected 00000000", n, aud.left_channel_audio_out);
            end
         end
      end
      vectors++;
      if (writes != 3) begin
         miscompares++; $display("[TB] FAIL mute_writes: got %0d expected 3", writes);
      end
      mute = 1'b0;
   endtask

   task automatic test_allowed_toggle();
      int writes;
      enable = 1'b1; mute = 1'b0; aud.audio_out_allowed = 1'b0; wave_in = 7'd1;
      do_reset();
      for (int n = 1; n <= 32; n++) begin
         wave_in = 7'(((n - 1) / 4) + 1);
         tick();
      end
      enable = 1'b0;
      writes = 0;
      for (int n = 1; n <= 60; n++) begin
         aud.audio_out_allowed = (((n - 1) / 3) % 2) == 1;
         tick();
         if (aud.write_audio_out === 1'b1) begin
            vectors++;
            if (aud.audio_out_allowed !== 1'b1) begin
               miscompares++;
               $display("[TB] FAIL toggle_gate: cycle %0d write began with allowed %b expected 1", n,
                        aud.audio_out_allowed);
            end
            vectors++;
            if (writes >= 8 || aud.left_channel_audio_out !== samp_tbl[writes % 10]) begin
               miscompares++;
               $display("[TB] FAIL toggle_order: write %0d got %h expected %h", writes,
                        aud.left_channel_audio_out, samp_tbl[writes % 10]);
            end
            writes++;
         end
      end
      vectors++;
      if (writes != 8 || fifo_level !== 4'd0) begin
         miscompares++;
         $display("[TB] FAIL toggle_count: got %0d writes level %0d expected 8 writes level 0", writes, fifo_level);
      end
   endtask

   task automatic test_reset_in_write();
      int writes;
      enable = 1'b1; mute = 1'b0; aud.audio_out_allowed = 1'b0; wave_in = 7'd1;
      do_reset();
      for (int n = 1; n <= 24; n++) begin
         wave_in = 7'(((n - 1) / 4) + 1);
         tick();
      end
      enable = 1'b0;
      aud.audio_out_allowed = 1'b1;
      tick();
      vectors++;
      if (aud.write_audio_out !== 1'b1 || fifo_level !== 4'd5) begin
         miscompares++;
         $display("[TB] FAIL rst_write_setup: got write %b level %0d expected 1 5", aud.write_audio_out, fifo_level);
      end
      reset = 1'b1;
      tick();
      vectors++;
      if (aud.write_audio_out !== 1'b0 || fifo_level !== 4'd0 || overrun !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL rst_write_state: got write %b level %0d ovr %b expected 0 0 0",
                  aud.write_audio_out, fifo_level, overrun);
      end
      vectors++;
      if (aud.left_channel_audio_out !== 32'h0 || aud.right_channel_audio_out !== 32'h0) begin
         miscompares++;
         $display("[TB] FAIL rst_write_data: got %h/%h expected 0/0", aud.left_channel_audio_out, aud.right_channel_audio_out);
      end
      reset = 1'b0;
      writes = 0;
      repeat (10) begin
         tick();
         if (aud.write_audio_out === 1'b1) writes++;
      end
      vectors++;
      if (writes != 0) begin
         miscompares++; $display("[TB] FAIL rst_write_discard: got %0d writes expected 0", writes);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      samp_tbl[0] = 32'h82000000; samp_tbl[1] = 32'h84000000;
      samp_tbl[2] = 32'h86000000; samp_tbl[3] = 32'h88000000;
      samp_tbl[4] = 32'h8A000000; samp_tbl[5] = 32'h8C000000;
      samp_tbl[6] = 32'h8E000000; samp_tbl[7] = 32'h90000000;
      samp_tbl[8] = 32'h92000000; samp_tbl[9] = 32'h94000000;
      reset = 1'b1; enable = 1'b0; mute = 1'b0; wave_in = '0;
      aud.audio_out_allowed = 1'b0;

      test_reset();
      test_conversion();
      test_overrun();
      test_full_pop();
      test_saturation();
      test_mute();
      test_allowed_toggle();
      test_reset_in_write();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
